tvla_seq_ctrl: RTL and testbench
================================

TVLA_SEQ_CTRL -- requirements
Module: tvla_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_IN  100  input words per transaction (1600-bit state / 16)
  N_OUT  100  output words per transaction
  AW  7  core address width; 2**AW >= max(N_IN, N_OUT)
  TRIG_PRE  4  trigger-high cycles before core_start
  TRIG_POST  4  trigger-high cycles after core_done
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  core clock
  rst_n  in  1  reset, asynchronous, active-low
  c2m_din  in  16  word from control FPGA
  c2m_en_lvl  in  1  toggles once per new c2m word
  c2m_done_lvl  out  1  toggles to acknowledge each c2m word
  m2c_dout  out  16  word to control FPGA
  m2c_en_lvl  out  1  toggles once per new m2c word
  m2c_done_lvl  in  1  control FPGA ack toggle for m2c
  core_wr_en  out  1  core input-write strobe
  core_wr_addr  out  AW  core input word index
  core_wr_data  out  16  core input word
  core_start  out  1  one-cycle start pulse
  core_done  in  1  one-cycle completion pulse
  core_rd_addr  out  AW  core output word index
  core_rd_data  in  16  core output word, valid 1 cycle after core_rd_addr
  trigger  out  1  scope trigger window
  device_rdy  out  1  high when waiting for first word of a transaction

Function
REQ-003 c2m_en_lvl and m2c_done_lvl SHALL each pass a 2-flop synchronizer before use.
REQ-004 States SHALL be RECV, PRE, RUN, POST, RD, SEND, WAIT_ACK.
REQ-005 RECV: word pending when synced c2m_en_lvl != c2m_done_lvl; SHALL capture c2m_din, pulse core_wr_en one cycle with core_wr_addr = word counter, toggle c2m_done_lvl same cycle, increment counter.
REQ-006 After word N_IN-1 is written, counter SHALL clear to 0 and state SHALL go to PRE next cycle.
REQ-007 PRE: trigger SHALL be 1 for exactly TRIG_PRE cycles; core_start SHALL pulse on the cycle leaving PRE, entering RUN.
REQ-008 RUN: SHALL wait for core_done; then POST with trigger held 1 for TRIG_POST more cycles; trigger SHALL be 0 in all other states.
REQ-009 TRIG_PRE or TRIG_POST = 0 SHALL skip that state (trigger not asserted for it).
REQ-010 RD: drive core_rd_addr = counter for one cycle; SEND: latch core_rd_data to m2c_dout and toggle m2c_en_lvl.
REQ-011 WAIT_ACK: wait until synced m2c_done_lvl == m2c_en_lvl; then increment counter and go to RD, or after word N_OUT-1 clear counter and go to RECV.
REQ-012 m2c_dout SHALL be stable from its m2c_en_lvl toggle until ack is observed.
REQ-013 c2m toggles arriving outside RECV SHALL not be acknowledged; they SHALL be served once RECV is re-entered (no word lost, none duplicated).
REQ-014 core_done outside RUN SHALL be ignored.
REQ-015 device_rdy SHALL be 1 only in RECV with counter = 0.
REQ-016 Counters SHALL be AW bits and never exceed N_IN-1 / N_OUT-1.

Reset
REQ-017 rst_n low SHALL asynchronously force state RECV, counters 0, synchronizers 0, and all outputs 0 except device_rdy = 1 (after deassertion only; 0 during reset).
REQ-018 Reset mid-transaction SHALL discard partial data; no core_start or m2c toggle SHALL occur for it.

Verification
REQ-019 Full transaction, N_IN=N_OUT=100, TRIG_PRE=TRIG_POST=4, core_done 24 cycles after start -> 100 writes addr 0..99, trigger high 4+24+1+4 cycles around core, 100 m2c words in address order, device_rdy returns 1.
REQ-020 Control FPGA delays m2c ack 50 cycles per word -> m2c_dout constant during each wait, no extra toggles.
REQ-021 c2m toggle issued during RUN -> not acked until RECV; then acked once, written to addr 0.
REQ-022 rst_n low after 37 input words -> all outputs 0, no core_start; next transaction writes from addr 0.
REQ-023 TRIG_PRE=0, TRIG_POST=0 -> core_start on cycle after last write; trigger only during RUN.
REQ-024 Spurious core_done during RECV -> ignored; state and counters unchanged.

Source files
------------

// File: rtl/tvla_seq_ctrl.sv
// tvla_seq_ctrl
// Sequences one TVLA measurement: receives N_IN 16-bit words from the control
// FPGA over a toggle handshake, writes them into the crypto core, brackets the
// core run with a scope trigger window, then reads N_OUT result words back and
// returns them to the control FPGA over a second toggle handshake.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   c2m_din/_en_lvl       inbound word and its "new word" toggle (async domain)
//   c2m_done_lvl          inbound acknowledge toggle
//   m2c_dout/_en_lvl      outbound word and its "new word" toggle
//   m2c_done_lvl          outbound acknowledge toggle (async domain)
//   core_wr_*             core input write port
//   core_start/_done      core run handshake (single-cycle pulses)
//   core_rd_addr/_data    core output read port, data valid one cycle after addr
//   trigger               scope trigger window around the core run
//   device_rdy            idle, waiting for the first word of a transaction
//
// state    | meaning
// ---------+------------------------------------------------------------
// RECV     | collect N_IN words from control FPGA, write each to the core
// PRE      | trigger high for TRIG_PRE cycles before core_start
// RUN      | core running, wait for core_done
// POST     | trigger held high for TRIG_POST cycles after core_done
// RD       | present core_rd_addr for the current output word
// SEND     | latch core_rd_data onto m2c_dout, toggle m2c_en_lvl
// WAIT_ACK | wait for control FPGA acknowledge of the current output word
module tvla_seq_ctrl #(
  parameter int N_IN      = 100,
  parameter int N_OUT     = 100,
  parameter int AW        = 7,
  parameter int TRIG_PRE  = 4,
  parameter int TRIG_POST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   c2m_din,
  input  logic          c2m_en_lvl,
  output logic          c2m_done_lvl,
  output logic [15:0]   m2c_dout,
  output logic          m2c_en_lvl,
  input  logic          m2c_done_lvl,
  output logic          core_wr_en,
  output logic [AW-1:0] core_wr_addr,
  output logic [15:0]   core_wr_data,
  output logic          core_start,
  input  logic          core_done,
  output logic [AW-1:0] core_rd_addr,
  input  logic [15:0]   core_rd_data,
  output logic          trigger,
  output logic          device_rdy
);

  localparam logic [2:0] S_RECV     = 3'd0;
  localparam logic [2:0] S_PRE      = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_POST     = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_WAIT_ACK = 3'd6;

  localparam int TMAX = (TRIG_PRE > TRIG_POST) ? TRIG_PRE : TRIG_POST;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] PRE_LOAD  = TW'((TRIG_PRE  > 0) ? TRIG_PRE  - 1 : 0);
  localparam logic [TW-1:0] POST_LOAD = TW'((TRIG_POST > 0) ? TRIG_POST - 1 : 0);
  localparam logic [AW-1:0] IN_LAST   = AW'(N_IN - 1);
  localparam logic [AW-1:0] OUT_LAST  = AW'(N_OUT - 1);

  logic [2:0]    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          fill_done, fill_done_nx;
  logic          start_nx;
  logic          c2m_en_s1, c2m_en_s2;
  logic          m2c_done_s1, m2c_done_s2;
  logic          c2m_pend;

  // fill_done marks the cycle the last input word is on the write port; no
  // word is accepted then, and the FSM leaves RECV on the following edge.
  assign c2m_pend     = (state == S_RECV) && !fill_done && (c2m_en_s2 != c2m_done_lvl);
  assign core_rd_addr = (state == S_RD) ? cnt : '0;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    tmr_nx       = tmr;
    fill_done_nx = fill_done;
    start_nx     = 1'b0;
    case (state)
      S_RECV: begin
        if (fill_done) begin
          fill_done_nx = 1'b0;
          if (TRIG_PRE > 0) begin
            state_nx = S_PRE;
            tmr_nx   = PRE_LOAD;
          end else begin
            state_nx = S_RUN;
            start_nx = 1'b1;
          end
        end else if (c2m_pend) begin
          if (cnt == IN_LAST) begin
            cnt_nx       = '0;
            fill_done_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_PRE: begin
        if (tmr == '0) begin
          state_nx = S_RUN;
          start_nx = 1'b1;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          if (TRIG_POST > 0) begin
            state_nx = S_POST;
            tmr_nx   = POST_LOAD;
          end else begin
            state_nx = S_RD;
          end
        end
      end
      S_POST: begin
        if (tmr == '0) state_nx = S_RD;
        else           tmr_nx   = tmr - 1'b1;
      end
      S_RD:   state_nx = S_SEND;
      S_SEND: state_nx = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (m2c_done_s2 == m2c_en_lvl) begin
          if (cnt == OUT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_RECV;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = S_RD;
          end
        end
      end
      default: state_nx = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RECV;
      cnt          <= '0;
      tmr          <= '0;
      fill_done    <= 1'b0;
      c2m_en_s1    <= 1'b0;
      c2m_en_s2    <= 1'b0;
      m2c_done_s1  <= 1'b0;
      m2c_done_s2  <= 1'b0;
      c2m_done_lvl <= 1'b0;
      m2c_dout     <= '0;
      m2c_en_lvl   <= 1'b0;
      core_wr_en   <= 1'b0;
      core_wr_addr <= '0;
      core_wr_data <= '0;
      core_start   <= 1'b0;
      trigger      <= 1'b0;
      device_rdy   <= 1'b0;
    end else begin
      c2m_en_s1    <= c2m_en_lvl;
      c2m_en_s2    <= c2m_en_s1;
      m2c_done_s1  <= m2c_done_lvl;
      m2c_done_s2  <= m2c_done_s1;
      state        <= state_nx;
      cnt          <= cnt_nx;
      tmr          <= tmr_nx;
      fill_done    <= fill_done_nx;
      core_start   <= start_nx;
      core_wr_en   <= c2m_pend;
      if (c2m_pend) begin
        core_wr_addr <= cnt;
        core_wr_data <= c2m_din;
        c2m_done_lvl <= ~c2m_done_lvl;
      end
      if (state == S_SEND) begin
        m2c_dout   <= core_rd_data;
        m2c_en_lvl <= ~m2c_en_lvl;
      end
      // Registered from next state so the scope sees a glitch-free window.
      trigger    <= (state_nx == S_PRE) || (state_nx == S_RUN) || (state_nx == S_POST);
      device_rdy <= (state_nx == S_RECV) && (cnt_nx == '0) && !fill_done_nx;
    end
  end

endmodule

// File: tb/tb_tvla_seq_ctrl.sv
module tb_tvla_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  // instance A: default parameters
  logic [15:0] c2m_din;
  logic        c2m_en_lvl, c2m_done_lvl;
  logic [15:0] m2c_dout;
  logic        m2c_en_lvl, m2c_done_lvl;
  logic        core_wr_en;
  logic [6:0]  core_wr_addr, core_rd_addr;
  logic [15:0] core_wr_data, core_rd_data;
  logic        core_start, core_done, trigger, device_rdy;
  // instance B: no trigger pre/post windows, 4-word transactions
  logic [15:0] b_c2m_din;
  logic        b_c2m_en_lvl, b_c2m_done_lvl;
  logic [15:0] b_m2c_dout;
  logic        b_m2c_en_lvl, b_m2c_done_lvl;
  logic        b_core_wr_en;
  logic [1:0]  b_core_wr_addr, b_core_rd_addr;
  logic [15:0] b_core_wr_data, b_core_rd_data;
  logic        b_core_start, b_core_done, b_trigger, b_device_rdy;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wr_q[$], b_wr_q[$];
  logic [15:0] out_q[$];
  logic [15:0] mem[128];
  logic [15:0] b_mem[4];
  int trig_cnt = 0, start_cnt = 0, tog_cnt = 0, wr_cnt = 0;
  int b_trig_cnt = 0, b_start_cyc = 0, b_last_wr = 0, cyc = 0;
  logic m2c_en_prev = 1'b0;

  always #5 clk = ~clk;

  tvla_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .c2m_din(c2m_din), .c2m_en_lvl(c2m_en_lvl), .c2m_done_lvl(c2m_done_lvl),
    .m2c_dout(m2c_dout), .m2c_en_lvl(m2c_en_lvl), .m2c_done_lvl(m2c_done_lvl),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_start(core_start), .core_done(core_done),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .trigger(trigger), .device_rdy(device_rdy)
  );

  tvla_seq_ctrl #(.N_IN(4), .N_OUT(4), .AW(2), .TRIG_PRE(0), .TRIG_POST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .c2m_din(b_c2m_din), .c2m_en_lvl(b_c2m_en_lvl), .c2m_done_lvl(b_c2m_done_lvl),
    .m2c_dout(b_m2c_dout), .m2c_en_lvl(b_m2c_en_lvl), .m2c_done_lvl(b_m2c_done_lvl),
    .core_wr_en(b_core_wr_en), .core_wr_addr(b_core_wr_addr), .core_wr_data(b_core_wr_data),
    .core_start(b_core_start), .core_done(b_core_done),
    .core_rd_addr(b_core_rd_addr), .core_rd_data(b_core_rd_data),
    .trigger(b_trigger), .device_rdy(b_device_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core models: output word = input word at same index XOR 5A5A, one-cycle read.
  always @(posedge clk) begin
    if (core_wr_en) mem[core_wr_addr] <= core_wr_data;
    core_rd_data <= mem[core_rd_addr] ^ 16'h5A5A;
    if (b_core_wr_en) b_mem[b_core_wr_addr] <= b_core_wr_data;
    b_core_rd_data <= b_mem[b_core_rd_addr] ^ 16'h5A5A;
  end

  // Monitor: write scoreboard and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc <= cyc + 1;
    m2c_en_prev <= m2c_en_lvl;
    if (rst_n) begin
      if (trigger)    trig_cnt  <= trig_cnt + 1;
      if (core_start) start_cnt <= start_cnt + 1;
      if (m2c_en_lvl !== m2c_en_prev) tog_cnt <= tog_cnt + 1;
      if (core_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        e = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
        chk("core_write", {9'd0, core_wr_addr, core_wr_data}, e);
      end
      if (b_trigger) b_trig_cnt <= b_trig_cnt + 1;
      if (b_core_start) b_start_cyc <= cyc;
      if (b_core_wr_en) begin
        b_last_wr <= cyc;
        e = (b_wr_q.size() > 0) ? b_wr_q.pop_front() : 32'hFFFF_FFFF;
        chk("b_core_write", {14'd0, b_core_wr_addr, b_core_wr_data}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [6:0] a, input logic [15:0] v);
    bit ok = 0;
    wr_q.push_back({9'd0, a, v});
    out_q.push_back(v ^ 16'h5A5A);
    c2m_din = v;
    c2m_en_lvl = ~c2m_en_lvl;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (c2m_done_lvl === c2m_en_lvl) begin ok = 1; break; end
    end
    if (!ok) chk("c2m_ack_timeout", 0, 1);
  endtask

  task automatic send_block(input int first, input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      send_word(7'(first + i), 16'(seed * 40503 + (first + i) * 12345 + 7));
      if (i == 0 && first == 0) chk("device_rdy_busy", device_rdy, 0);
    end
  endtask

  task automatic core_phase(input bit inject, input logic [15:0] iv);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (core_start === 1'b1) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin chk("core_start_timeout", 0, 1); return; end
    tick();
    chk("core_start_width", core_start, 0);
    chk("trigger_in_run", trigger, 1);
    if (inject) begin
      wr_q.push_back({9'd0, 7'd0, iv});
      out_q.push_back(iv ^ 16'h5A5A);
      c2m_din = iv;
      c2m_en_lvl = ~c2m_en_lvl;
    end
    for (int i = 0; i < 23; i++) begin
      tick();
      if (inject && i == 9) chk("c2m_not_acked_in_run", c2m_done_lvl !== c2m_en_lvl, 1);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic recv_block(input int n, input int delay);
    for (int k = 0; k < n; k++) begin
      bit ok = 0;
      bit stable;
      logic [15:0] d0, e;
      logic en0;
      for (int i = 0; i < 300; i++) begin
        if (m2c_en_lvl !== m2c_done_lvl) begin ok = 1; break; end
        tick();
      end
      if (!ok) begin chk("m2c_word_timeout", 0, 1); return; end
      e = (out_q.size() > 0) ? out_q.pop_front() : 16'hDEAD;
      chk("m2c_dout", m2c_dout, e);
      if (delay > 0) begin
        d0 = m2c_dout; en0 = m2c_en_lvl; stable = 1;
        repeat (delay) begin
          tick();
          if (m2c_dout !== d0 || m2c_en_lvl !== en0) stable = 0;
        end
        chk("m2c_stable_during_wait", stable, 1);
      end
      m2c_done_lvl = m2c_en_lvl;
      tick();
    end
  endtask

  task automatic wait_rdy(input string tag);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (device_rdy === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk(tag, ok, 1);
  endtask

  task automatic full_txn(input int seed, input int delay, input bit spur);
    int t0, s0, g0;
    t0 = trig_cnt; s0 = start_cnt; g0 = tog_cnt;
    if (spur) begin
      send_block(0, 10, seed);
      core_done = 1'b1; tick(); core_done = 1'b0;
      repeat (5) tick();
      chk("spur_done_no_start", start_cnt - s0, 0);
      chk("spur_done_no_trigger", trigger, 0);
      send_block(10, 90, seed);
    end else begin
      send_block(0, 100, seed);
    end
    core_phase(0, 16'h0);
    recv_block(100, delay);
    chk("trigger_window_len", trig_cnt - t0, 33);
    chk("core_start_count", start_cnt - s0, 1);
    chk("m2c_toggle_count", tog_cnt - g0, 100);
    wait_rdy("device_rdy_after_txn");
    chk("trigger_idle", trigger, 0);
  endtask

  initial begin
    int s0, g0, t0;
    bit ok;
    rst_n = 1'b0;
    c2m_din = '0; c2m_en_lvl = 0; m2c_done_lvl = 0; core_done = 0;
    b_c2m_din = '0; b_c2m_en_lvl = 0; b_m2c_done_lvl = 0; b_core_done = 0;
    repeat (3) tick();
    chk("reset_outputs", {c2m_done_lvl, m2c_dout, m2c_en_lvl, core_wr_en, core_wr_addr,
        core_wr_data, core_start, core_rd_addr, trigger, device_rdy}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("device_rdy_after_reset", device_rdy, 1);
    chk("idle_outputs", {c2m_done_lvl, m2c_en_lvl, core_wr_en, core_start, trigger}, 5'd0);

    // Spurious core_done while idle in RECV.
    core_done = 1'b1; tick(); core_done = 1'b0;
    repeat (5) tick();
    chk("spur_idle_rdy", device_rdy, 1);
    chk("spur_idle_start", start_cnt, 0);

    full_txn(1, 0, 1);
    full_txn(2, 50, 0);

    // Word toggled during RUN: held off until RECV, then written once at addr 0.
    send_block(0, 100, 3);
    core_phase(1, 16'hBEEF);
    recv_block(100, 0);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (c2m_done_lvl === c2m_en_lvl) begin ok = 1; break; end
      tick();
    end
    chk("run_toggle_acked_in_recv", ok, 1);
    repeat (3) tick();
    chk("run_toggle_single_write", wr_q.size(), 0);
    send_block(1, 36, 4);

    // Reset after 37 input words.
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midtxn_reset_outputs", {c2m_done_lvl, m2c_dout, m2c_en_lvl, core_wr_en, core_wr_addr,
        core_wr_data, core_start, core_rd_addr, trigger, device_rdy}, 64'd0);
    c2m_en_lvl = 0; m2c_done_lvl = 0;
    chk("midtxn_no_pending_writes", wr_q.size(), 0);
    out_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    s0 = start_cnt; g0 = tog_cnt; t0 = trig_cnt;
    repeat (40) tick();
    chk("midtxn_no_core_start", start_cnt - s0, 0);
    chk("midtxn_no_m2c_toggle", tog_cnt - g0, 0);
    chk("midtxn_no_trigger", trig_cnt - t0, 0);
    chk("midtxn_rdy", device_rdy, 1);
    full_txn(5, 0, 0);

    // Instance B: TRIG_PRE = TRIG_POST = 0.
    for (int i = 0; i < 4; i++) begin
      logic [15:0] v;
      v = 16'(i * 4099 + 16'h1234);
      b_wr_q.push_back({14'd0, 2'(i), v});
      b_c2m_din = v;
      b_c2m_en_lvl = ~b_c2m_en_lvl;
      ok = 0;
      for (int j = 0; j < 20; j++) begin
        tick();
        if (b_c2m_done_lvl === b_c2m_en_lvl) begin ok = 1; break; end
      end
      if (!ok) chk("b_c2m_ack_timeout", 0, 1);
    end
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (b_core_start === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk("b_core_start_seen", ok, 1);
    repeat (5) tick();
    b_core_done = 1'b1; tick(); b_core_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        if (b_m2c_en_lvl !== b_m2c_done_lvl) begin ok = 1; break; end
        tick();
      end
      if (!ok) begin chk("b_m2c_word_timeout", 0, 1); break; end
      chk("b_m2c_dout", b_m2c_dout, 16'(k * 4099 + 16'h1234) ^ 16'h5A5A);
      b_m2c_done_lvl = b_m2c_en_lvl;
      tick();
    end
    chk("b_start_after_last_write", b_start_cyc - b_last_wr, 1);
    chk("b_trigger_run_only", b_trig_cnt, 6);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (b_device_rdy === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk("b_device_rdy_after_txn", ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
